fft_frame_controller: RTL and testbench

FFT_FRAME_CONTROLLER -- requirements
Module: fft_frame_controller

---
 rtl/fft_frame_controller_pkg.sv | 25 ++
 rtl/fft_frame_controller.sv | 153 +++++++++++++++
 tb/tb_fft_frame_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fft_frame_controller_pkg
//  Purpose : Shared constants and FSM state type for the FFT frame controller
//            and the FFT datapath it feeds.
//  Contents: SAMPLE_SIZE  - bits per time-domain sample / magnitude word
//            BUFFER_SIZE  - samples (and bins) per frame, power of two
//            TWIDDLE_SIZE - twiddle factor width used by the FFT core
//            frame_state_t- controller state encoding
//  Revision: 1.0 - initial release
// ============================================================================
package fft_frame_controller_pkg;

  localparam int SAMPLE_SIZE  = 16;
  localparam int BUFFER_SIZE  = 8;
  localparam int TWIDDLE_SIZE = 16;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module  : fft_frame_controller
//  Purpose : Collects one frame of samples, presents it to a combinational
//            FFT/magnitude path, waits for it to settle, captures the result
//            and streams the bins out with a valid/ready handshake.
//  Ports   : clk, rst (async, active-high)
//            in_sample/in_valid/in_ready       - sample input stream
//            fft_input_bitstream               - frame to FFT (slot i at
//                                                [i*SAMPLE_SIZE +: SAMPLE_SIZE])
//            fft_output_bitstream              - magnitudes back from FFT
//            out_mag/out_valid/out_ready/out_last - bin output stream
//            busy                              - high while settling/draining
//  Revision: 1.0 - initial release
// ============================================================================
module fft_frame_controller
  import fft_frame_controller_pkg::*;
#(
  parameter int SAMPLE_SIZE   = fft_frame_controller_pkg::SAMPLE_SIZE,
  parameter int BUFFER_SIZE   = fft_frame_controller_pkg::BUFFER_SIZE,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [SAMPLE_SIZE-1:0]       in_sample,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  fft_input_bitstream,
  input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  fft_output_bitstream,
  output logic [SAMPLE_SIZE-1:0]              out_mag,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy
);

  localparam int IDX_W   = $clog2(BUFFER_SIZE);
  // A single settle cycle still needs a 1-bit counter to hold its value.
  localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FRAME_W = BUFFER_SIZE * SAMPLE_SIZE;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  frame_state_t     r_state;
  frame_state_t     w_next_state;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [FRAME_W-1:0] r_frame;
  logic [FRAME_W-1:0] r_mags;

  logic w_accept;
  logic w_emit;
  logic w_capture;

  assign fft_input_bitstream = r_frame;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs. All handshake outputs decode directly from the
  // state so they follow rst immediately, without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_mag      = '0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    w_emit       = 1'b0;
    w_capture    = 1'b0;

    case (r_state)
      ST_FILL: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (w_accept && (r_wr_idx == LAST_IDX)) begin
          w_next_state = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        busy = 1'b1;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_capture    = 1'b1;
          w_next_state = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_mag   = r_mags[r_rd_idx*SAMPLE_SIZE +: SAMPLE_SIZE];
        out_last  = (r_rd_idx == LAST_IDX);
        w_emit    = out_ready;
        if (w_emit && out_last) begin
          w_next_state = ST_FILL;
        end
      end

      default: begin
        w_next_state = ST_FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: frame buffer, capture register and indices
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_settle_cnt <= '0;
      r_frame      <= '0;
      r_mags       <= '0;
    end else begin
      if (w_accept) begin
        r_frame[r_wr_idx*SAMPLE_SIZE +: SAMPLE_SIZE] <= in_sample;
        r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + 1'b1;
        if (r_wr_idx == LAST_IDX) begin
          r_settle_cnt <= '0;
        end
      end

      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end

      if (w_capture) begin
        r_mags <= fft_output_bitstream;
      end

      if (w_emit) begin
        r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fft_frame_controller
//  Purpose : Directed self-checking bench for fft_frame_controller
//            (BUFFER_SIZE=8, SAMPLE_SIZE=16, SETTLE_CYCLES=2).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_fft_frame_controller;

  localparam int SS = 16;
  localparam int BS = 8;
  localparam int FW = SS * BS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SS-1:0] in_sample = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] fft_input_bitstream;
  logic [FW-1:0] fft_output_bitstream = '0;
  logic [SS-1:0] out_mag;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_frame_controller #(
    .SAMPLE_SIZE  (SS),
    .BUFFER_SIZE  (BS),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_sample           (in_sample),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .fft_input_bitstream (fft_input_bitstream),
    .fft_output_bitstream(fft_output_bitstream),
    .out_mag             (out_mag),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_last            (out_last),
    .busy                (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] make_frame(input int start);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < BS; i++) f[i*SS +: SS] = SS'(start + i);
    return f;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  FW'(in_ready),  FW'(1));
    check({tag, "_out_valid"}, FW'(out_valid), FW'(0));
    check({tag, "_out_last"},  FW'(out_last),  FW'(0));
    check({tag, "_out_mag"},   FW'(out_mag),   FW'(0));
    check({tag, "_busy"},      FW'(busy),      FW'(0));
  endtask

  // Feeds count consecutive samples start, start+1, ... with in_valid held high.
  task automatic feed(input int start, input int count);
    for (int i = 0; i < count; i++) begin
      in_sample = SS'(start + i);
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check(tag, FW'(out_valid), FW'(1));
  endtask

  // Drains a whole frame with out_ready high, checking order and out_last.
  task automatic drain_all(input string tag, input int base);
    out_ready = 1'b1;
    for (int k = 0; k < BS; k++) begin
      check({tag, "_mag"},  FW'(out_mag),  FW'(base + k));
      check({tag, "_last"}, FW'(out_last), FW'(k == BS - 1));
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int k;
    int c;
    int n;
    logic [3:0] pat;

    // ---------------- reset state ----------------
    #2;
    check_idle("reset");
    check("reset_frame", fft_input_bitstream, '0);
    tick();
    rst = 1'b0;
    tick();

    // ---------------- frame 1..8, full-rate ----------------
    fft_output_bitstream = make_frame(16'h0100);
    feed(1, 8);
    // keep offering a sample during SETTLE; it must be ignored
    in_sample = 16'h0099;
    in_valid  = 1'b1;
    check("a_in_ready_low", FW'(in_ready), FW'(0));
    check("a_busy", FW'(busy), FW'(1));
    check("a_frame", fft_input_bitstream, make_frame(1));
    check("a_valid_c1", FW'(out_valid), FW'(0));
    tick();
    check("a_valid_c2", FW'(out_valid), FW'(0));
    tick();
    check("a_valid_c3", FW'(out_valid), FW'(1));
    in_valid = 1'b0;
    // results already captured; changing FFT output must not affect the bins
    fft_output_bitstream = make_frame(16'h0E00);
    check("a_frame_held", fft_input_bitstream, make_frame(1));
    drain_all("a", 16'h0100);
    check_idle("a_after");

    // ---------------- back-to-back frame 9..16, out_ready toggling ----------------
    fft_output_bitstream = make_frame(16'h0200);
    feed(9, 8);
    check("b_frame", fft_input_bitstream, make_frame(9));
    wait_valid("b_wait_valid");
    fft_output_bitstream = '0;
    pat = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 0 first)
    k = 0;
    c = 0;
    while (k < BS && c < 40) begin
      out_ready = pat[c % 4];
      check("b_valid", FW'(out_valid), FW'(1));
      check("b_mag",   FW'(out_mag),   FW'(16'h0200 + k));
      check("b_last",  FW'(out_last),  FW'(k == BS - 1));
      if (out_ready) k++;
      tick();
      c++;
    end
    out_ready = 1'b0;
    check("b_bins_emitted", FW'(k), FW'(BS));
    check_idle("b_after");

    // ---------------- gapped in_valid (every third cycle) ----------------
    fft_output_bitstream = make_frame(16'h0300);
    n = 0;
    c = 0;
    while (n < BS && c < 60) begin
      in_valid  = (c % 3 == 0);
      in_sample = in_valid ? SS'(n + 1) : 16'h7777;
      tick();
      if (in_valid) n++;
      c++;
    end
    in_valid = 1'b0;
    check("c_frame", fft_input_bitstream, make_frame(1));
    check("c_in_ready_low", FW'(in_ready), FW'(0));
    wait_valid("c_wait_valid");
    drain_all("c", 16'h0300);
    check_idle("c_after");

    // ---------------- reset after 5 samples ----------------
    feed(16'h0050, 5);
    #2;
    rst = 1'b1;
    #1;
    check_idle("d_rst");
    check("d_rst_frame", fft_input_bitstream, '0);
    #1;
    rst = 1'b0;
    tick();
    fft_output_bitstream = make_frame(16'h0400);
    feed(16'h0011, 8);
    check("d_fresh_frame", fft_input_bitstream, make_frame(16'h0011));
    wait_valid("d_wait_valid");

    // ---------------- reset during DRAIN bin 3 ----------------
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    check("e_bin3", FW'(out_mag), FW'(16'h0403));
    #2;
    rst = 1'b1;
    #1;
    check_idle("e_rst");
    check("e_rst_frame", fft_input_bitstream, '0);
    #1;
    rst = 1'b0;
    tick();
    fft_output_bitstream = make_frame(16'h0500);
    feed(1, 8);
    check("e_fresh_frame", fft_input_bitstream, make_frame(1));
    wait_valid("e_wait_valid");
    drain_all("e", 16'h0500);
    check_idle("e_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
